// File: rtl/spi_bus_arbiter_if.sv
// Purpose: bundles the CPU, debug and SPI-master handshake signals of the SPI bus arbiter.
// Latency: wiring only, no storage.
// Backpressure: none here; requesters hold req until ack, the SPI side stalls grants via spiBusy_i.
// Ports (slave = arbiter view):
//   cpu*/dbg*  : req/rwb/addr/wdata in, ack pulse and registered read data out
//   spi*       : start pulse and latched rwb/addr/wdata out, busy/done/rdata in
//   ownerDbg_o, timeout_o, state_o : status readout
interface spi_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cpuReq_i;
    logic              cpuRwb_i;
    logic [ADDR_W-1:0] cpuAddr_i;
    logic [DATA_W-1:0] cpuWdata_i;
    logic              cpuAck_o;
    logic [DATA_W-1:0] cpuRdata_o;

    logic              dbgReq_i;
    logic              dbgRwb_i;
    logic [ADDR_W-1:0] dbgAddr_i;
    logic [DATA_W-1:0] dbgWdata_i;
    logic              dbgAck_o;
    logic [DATA_W-1:0] dbgRdata_o;

    logic              spiStart_o;
    logic              spiRwb_o;
    logic [ADDR_W-1:0] spiAddr_o;
    logic [DATA_W-1:0] spiWdata_o;
    logic              spiBusy_i;
    logic              spiDone_i;
    logic [DATA_W-1:0] spiRdata_i;

    logic              ownerDbg_o;
    logic              timeout_o;
    logic [1:0]        state_o;

    modport slave (
        input  cpuReq_i, cpuRwb_i, cpuAddr_i, cpuWdata_i,
        output cpuAck_o, cpuRdata_o,
        input  dbgReq_i, dbgRwb_i, dbgAddr_i, dbgWdata_i,
        output dbgAck_o, dbgRdata_o,
        output spiStart_o, spiRwb_o, spiAddr_o, spiWdata_o,
        input  spiBusy_i, spiDone_i, spiRdata_i,
        output ownerDbg_o, timeout_o, state_o
    );

    modport master (
        output cpuReq_i, cpuRwb_i, cpuAddr_i, cpuWdata_i,
        input  cpuAck_o, cpuRdata_o,
        output dbgReq_i, dbgRwb_i, dbgAddr_i, dbgWdata_i,
        input  dbgAck_o, dbgRdata_o,
        input  spiStart_o, spiRwb_o, spiAddr_o, spiWdata_o,
        output spiBusy_i, spiDone_i, spiRdata_i,
        input  ownerDbg_o, timeout_o, state_o
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Purpose: round-robin share of one SPI master between the CPU path and the debug port.
// Latency: grant edge -> START (1 cycle) -> WAIT (N cycles, capped at TIMEOUT) -> ACK (1 cycle).
// Backpressure: grants stall while spiBusy_i is high; a losing requester waits, holding req.
// Ports:
//   clk, resetb : clock and synchronous active-low reset
//   bus (slave) : CPU/debug request + ack/rdata, SPI master start/busy/done, status readout
module spi_bus_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             resetb,
    spi_bus_arbiter_if.slave bus
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_dbg_q, last_dbg_d;
    logic              owner_dbg_q, owner_dbg_d;
    logic              rwb_q, rwb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              start_q, start_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              grant_dbg;
    logic              timeout_pulse;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_dbg_d    = last_dbg_q;
        owner_dbg_d   = owner_dbg_q;
        rwb_d         = rwb_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        start_d       = 1'b0;
        cpu_ack_d     = 1'b0;
        dbg_ack_d     = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        dbg_rdata_d   = dbg_rdata_q;
        timeout_pulse = 1'b0;

        // Debug wins when it is the only requester, or when both request and
        // the CPU was served last.
        grant_dbg = bus.dbgReq_i & (~bus.cpuReq_i | ~last_dbg_q);

        case (state_q)
            IDLE: begin
                if ((bus.cpuReq_i | bus.dbgReq_i) & ~bus.spiBusy_i) begin
                    owner_dbg_d = grant_dbg;
                    last_dbg_d  = grant_dbg;
                    rwb_d       = grant_dbg ? bus.dbgRwb_i   : bus.cpuRwb_i;
                    addr_d      = grant_dbg ? bus.dbgAddr_i  : bus.cpuAddr_i;
                    wdata_d     = grant_dbg ? bus.dbgWdata_i : bus.cpuWdata_i;
                    start_d     = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Done is checked first so a done on the last allowed cycle
                // completes normally without flagging a timeout.
                if (bus.spiDone_i) begin
                    if (rwb_q) begin
                        if (owner_dbg_q) dbg_rdata_d = bus.spiRdata_i;
                        else             cpu_rdata_d = bus.spiRdata_i;
                    end
                    cpu_ack_d = ~owner_dbg_q;
                    dbg_ack_d = owner_dbg_q;
                    state_d   = ACK;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_pulse = 1'b1;
                    if (rwb_q) begin
                        if (owner_dbg_q) dbg_rdata_d = {DATA_W{1'b1}};
                        else             cpu_rdata_d = {DATA_W{1'b1}};
                    end
                    cpu_ack_d = ~owner_dbg_q;
                    dbg_ack_d = owner_dbg_q;
                    state_d   = ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_dbg_q  <= 1'b1;
            owner_dbg_q <= 1'b0;
            rwb_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            start_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_dbg_q  <= last_dbg_d;
            owner_dbg_q <= owner_dbg_d;
            rwb_q       <= rwb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            start_q     <= start_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign bus.cpuAck_o   = cpu_ack_q;
    assign bus.cpuRdata_o = cpu_rdata_q;
    assign bus.dbgAck_o   = dbg_ack_q;
    assign bus.dbgRdata_o = dbg_rdata_q;
    assign bus.spiStart_o = start_q;
    assign bus.spiRwb_o   = rwb_q;
    assign bus.spiAddr_o  = addr_q;
    assign bus.spiWdata_o = wdata_q;
    assign bus.ownerDbg_o = owner_dbg_q;
    // The timeout flag must appear in the WAIT cycle that expires and must be
    // suppressed by a same-cycle done, so it is decoded from the registered
    // state/counter and the live done input rather than registered itself.
    assign bus.timeout_o  = timeout_pulse;
    assign bus.state_o    = state_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
module tb_spi_bus_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic resetb;
    always #5 clk = ~clk;

    spi_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    spi_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    typedef struct {
        bit          dbg;
        bit          rwb;
        logic [AW-1:0] addr;
        int          ack_cyc;
        int          to_cyc;
        logic [DW-1:0] exp_cpu_rd;
        logic [DW-1:0] exp_dbg_rd;
    } exp_t;

    exp_t exp_q[$];
    bit   owner_log[$];

    int checks = 0;
    int failures = 0;

    // reference-model state
    int          cyc = 0;
    bit          m_idle = 1'b1;
    bit          exp_start = 1'b0;
    bit          m_last_dbg = 1'b1;
    bit          snap_dbg;
    logic        snap_rwb;
    logic [AW-1:0] snap_addr;
    logic [DW-1:0] snap_wdata;
    logic [DW-1:0] m_cpu_rd = '0;
    logic [DW-1:0] m_dbg_rd = '0;
    int          done_cyc = -1;
    logic [DW-1:0] done_rd = '0;
    int          forced_n = 0;
    logic [DW-1:0] forced_rd = '0;
    int          start_cnt = 0;
    int          to_cnt = 0;
    int          last_start_cyc = -1;
    bit          rand_busy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"},    64'(bus.state_o),    64'(0));
        chk({tag, "_cpuAck"},   64'(bus.cpuAck_o),   64'(0));
        chk({tag, "_dbgAck"},   64'(bus.dbgAck_o),   64'(0));
        chk({tag, "_spiStart"}, 64'(bus.spiStart_o), 64'(0));
        chk({tag, "_spiRwb"},   64'(bus.spiRwb_o),   64'(0));
        chk({tag, "_spiAddr"},  64'(bus.spiAddr_o),  64'(0));
        chk({tag, "_spiWdata"}, 64'(bus.spiWdata_o), 64'(0));
        chk({tag, "_ownerDbg"}, 64'(bus.ownerDbg_o), 64'(0));
        chk({tag, "_timeout"},  64'(bus.timeout_o),  64'(0));
        chk({tag, "_cpuRdata"}, 64'(bus.cpuRdata_o), 64'(0));
        chk({tag, "_dbgRdata"}, 64'(bus.dbgRdata_o), 64'(0));
    endtask

    // Called right after a posedge (+#1); returns right after the posedge that
    // ends the ack cycle, dropping req there when asked to.
    task automatic cpu_txn(input logic rwb, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit drop);
        bit got = 1'b0;
        bus.cpuRwb_i = rwb; bus.cpuAddr_i = a; bus.cpuWdata_i = d; bus.cpuReq_i = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (bus.cpuAck_o) got = 1'b1;
        end
        chk("cpu_ack_within_budget", 64'(got), 64'(1));
        @(posedge clk); #1;
        if (drop) bus.cpuReq_i = 1'b0;
    endtask

    task automatic dbg_txn(input logic rwb, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit drop);
        bit got = 1'b0;
        bus.dbgRwb_i = rwb; bus.dbgAddr_i = a; bus.dbgWdata_i = d; bus.dbgReq_i = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (bus.dbgAck_o) got = 1'b1;
        end
        chk("dbg_ack_within_budget", 64'(got), 64'(1));
        @(posedge clk); #1;
        if (drop) bus.dbgReq_i = 1'b0;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        resetb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetb = 1'b1;
    endtask

    // SPI master stand-in: raises done for the single cycle the model scheduled.
    initial begin
        bus.spiDone_i  = 1'b0;
        bus.spiRdata_i = '0;
        forever begin
            @(posedge clk); #1;
            if (done_cyc == cyc + 1) begin
                bus.spiDone_i  = 1'b1;
                bus.spiRdata_i = done_rd;
            end else begin
                bus.spiDone_i  = 1'b0;
                bus.spiRdata_i = $urandom;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_busy) bus.spiBusy_i = ($urandom_range(0, 3) == 0);
        end
    end

    // Reference model + scoreboard, sampled mid-cycle.
    initial begin
        exp_t e;
        int n;
        logic [DW-1:0] rd;
        logic [DW-1:0] val;
        bit ack_seen;
        bit exp_to;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.spiStart_o) begin start_cnt++; last_start_cyc = cyc; end
            if (bus.timeout_o) to_cnt++;
            if (!resetb) begin
                exp_q.delete();
                m_idle = 1'b1; exp_start = 1'b0; m_last_dbg = 1'b1;
                m_cpu_rd = '0; m_dbg_rd = '0; done_cyc = -1;
            end else begin
                if (bus.spiStart_o || exp_start)
                    chk("spi_start", 64'(bus.spiStart_o), 64'(exp_start));
                if (bus.spiStart_o && exp_start) begin
                    chk("start_owner_dbg", 64'(bus.ownerDbg_o), 64'(snap_dbg));
                    chk("start_rwb",       64'(bus.spiRwb_o),   64'(snap_rwb));
                    chk("start_addr",      64'(bus.spiAddr_o),  64'(snap_addr));
                    chk("start_wdata",     64'(bus.spiWdata_o), 64'(snap_wdata));
                    owner_log.push_back(snap_dbg);
                    n  = (forced_n != 0) ? forced_n : $urandom_range(1, TO + 2);
                    rd = (forced_n != 0) ? forced_rd : $urandom;
                    e.dbg = snap_dbg; e.rwb = snap_rwb; e.addr = snap_addr;
                    e.ack_cyc = cyc + ((n > TO) ? TO : n) + 1;
                    e.to_cyc  = (n > TO) ? cyc + TO : -1;
                    e.exp_cpu_rd = m_cpu_rd;
                    e.exp_dbg_rd = m_dbg_rd;
                    if (snap_rwb) begin
                        val = (n > TO) ? {DW{1'b1}} : rd;
                        if (snap_dbg) e.exp_dbg_rd = val;
                        else          e.exp_cpu_rd = val;
                    end
                    done_cyc = (n <= TO) ? cyc + n : -1;
                    done_rd  = rd;
                    exp_q.push_back(e);
                end
                exp_to = (exp_q.size() > 0) && (exp_q[0].to_cyc == cyc);
                if (bus.timeout_o || exp_to)
                    chk("timeout_pulse", 64'(bus.timeout_o), 64'(exp_to));
                ack_seen = bus.cpuAck_o || bus.dbgAck_o;
                if (ack_seen) begin
                    if (exp_q.size() == 0) begin
                        chk("ack_unexpected", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_cycle",     64'(cyc),            64'(e.ack_cyc));
                        chk("ack_dbg",       64'(bus.dbgAck_o),   64'(e.dbg));
                        chk("ack_cpu",       64'(bus.cpuAck_o),   64'(!e.dbg));
                        chk("ack_cpu_rdata", 64'(bus.cpuRdata_o), 64'(e.exp_cpu_rd));
                        chk("ack_dbg_rdata", 64'(bus.dbgRdata_o), 64'(e.exp_dbg_rd));
                        chk("ack_hold_addr", 64'(bus.spiAddr_o),  64'(e.addr));
                        chk("ack_hold_own",  64'(bus.ownerDbg_o), 64'(e.dbg));
                        m_cpu_rd = e.exp_cpu_rd;
                        m_dbg_rd = e.exp_dbg_rd;
                    end
                end else if (exp_q.size() > 0 && exp_q[0].ack_cyc == cyc) begin
                    chk("ack_missing", 64'(0), 64'(1));
                    e = exp_q.pop_front();
                    ack_seen = 1'b1;
                end
                exp_start = m_idle && (bus.cpuReq_i || bus.dbgReq_i) && !bus.spiBusy_i;
                if (exp_start) begin
                    snap_dbg   = (bus.cpuReq_i && bus.dbgReq_i) ? !m_last_dbg : bus.dbgReq_i;
                    snap_rwb   = snap_dbg ? bus.dbgRwb_i   : bus.cpuRwb_i;
                    snap_addr  = snap_dbg ? bus.dbgAddr_i  : bus.cpuAddr_i;
                    snap_wdata = snap_dbg ? bus.dbgWdata_i : bus.cpuWdata_i;
                    m_last_dbg = snap_dbg;
                    m_idle     = 1'b0;
                end
                if (ack_seen) m_idle = 1'b1;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog_expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int t0;
        int low_cyc;
        int g;
        bit exp_owner[4];
        resetb = 1'b0;
        bus.cpuReq_i = 0; bus.cpuRwb_i = 0; bus.cpuAddr_i = '0; bus.cpuWdata_i = '0;
        bus.dbgReq_i = 0; bus.dbgRwb_i = 0; bus.dbgAddr_i = '0; bus.dbgWdata_i = '0;
        bus.spiBusy_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1;
        resetb = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // CPU read, done on the 3rd WAIT cycle
        forced_n = 3; forced_rd = 32'hDEADBEEF; s0 = start_cnt;
        cpu_txn(1'b1, 16'h0010, 32'h0, 1'b1);
        chk("t1_start_count", 64'(start_cnt - s0), 64'(1));
        chk("t1_cpu_rdata",   64'(bus.cpuRdata_o), 64'(32'hDEADBEEF));
        chk("t1_spi_addr",    64'(bus.spiAddr_o),  64'(16'h0010));
        chk("t1_spi_rwb",     64'(bus.spiRwb_o),   64'(1));

        // debug write leaves debug read data untouched
        forced_n = 2; forced_rd = 32'hCAFEF00D;
        dbg_txn(1'b0, 16'h0003, 32'h12345678, 1'b1);
        chk("t3_spi_rwb",    64'(bus.spiRwb_o),   64'(0));
        chk("t3_spi_wdata",  64'(bus.spiWdata_o), 64'(32'h12345678));
        chk("t3_dbg_rdata",  64'(bus.dbgRdata_o), 64'(0));
        chk("t3_owner_dbg",  64'(bus.ownerDbg_o), 64'(1));

        // unresponsive slave
        forced_n = TO + 2; t0 = to_cnt;
        cpu_txn(1'b1, 16'h0020, 32'h0, 1'b1);
        chk("t4_cpu_rdata",    64'(bus.cpuRdata_o), 64'(32'hFFFFFFFF));
        chk("t4_timeout_count", 64'(to_cnt - t0),   64'(1));

        // busy holds the grant back for 5 cycles
        forced_n = 1; forced_rd = 32'h0;
        bus.spiBusy_i = 1'b1; low_cyc = 0;
        fork
            cpu_txn(1'b0, 16'h0030, 32'hA5A5A5A5, 1'b1);
            begin
                repeat (5) @(posedge clk);
                #1;
                bus.spiBusy_i = 1'b0;
                low_cyc = cyc + 1;
            end
        join
        chk("t6_start_after_busy", 64'(last_start_cyc), 64'(low_cyc + 1));

        // both requesting from reset: strict alternation starting with CPU
        reset_pulse();
        owner_log.delete();
        forced_n = 0;
        fork
            for (int k = 0; k < 2; k++) cpu_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, k == 1);
            for (int k = 0; k < 2; k++) dbg_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, k == 1);
        join
        exp_owner[0] = 1'b0; exp_owner[1] = 1'b1; exp_owner[2] = 1'b0; exp_owner[3] = 1'b1;
        chk("t2_owner_count", 64'(owner_log.size()), 64'(4));
        for (int k = 0; k < 4 && k < owner_log.size(); k++)
            chk("t2_owner_order", 64'(owner_log[k]), 64'(exp_owner[k]));

        // reset while waiting on the slave, then a normal completion
        forced_n = TO + 2;
        fork
            cpu_txn(1'b1, 16'h0044, 32'h0, 1'b1);
            begin
                for (int i = 0; i < 50 && !bus.spiStart_o; i++) @(negedge clk);
                @(posedge clk); #1;
                @(posedge clk); #1;
                forced_n = 2; forced_rd = 32'h0BADF00D;
                resetb = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check_reset_outputs("t5");
                @(posedge clk); #1;
                resetb = 1'b1;
            end
        join
        chk("t5_cpu_rdata_after", 64'(bus.cpuRdata_o), 64'(32'h0BADF00D));

        // randomized traffic with random busy
        forced_n = 0;
        rand_busy = 1'b1;
        fork
            for (int k = 0; k < 30; k++) begin
                g = $urandom_range(0, 3);
                repeat (g) begin @(posedge clk); #1; end
                cpu_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 1'b1);
            end
            for (int k = 0; k < 30; k++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                dbg_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 1'b1);
            end
        join
        rand_busy = 1'b0;
        bus.spiBusy_i = 1'b0;

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
